seg_display_decoder: RTL and testbench

SEG_DISPLAY_DECODER -- requirements
Module: seg_display_decoder

---
 rtl/seg_display_decoder.sv | 137 +++++++++++++
 tb/tb_seg_display_decoder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/seg_display_decoder.sv
// seg_display_decoder
//   Recovers two hex digits from a multiplexed, active-low seven-segment
//   drive. A digit is accepted once {seg, display_select} has been seen
//   identical on STABLE_CNT consecutive registered samples. After that,
//   the digit is decoded and latched. A running sum of both digits is
//   also kept.
//
// Ports
//   clk             system clock, rising edge
//   reset           synchronous reset, active low
//   seg[6:0]        segment drive, active low (bit 6 = g .. bit 0 = a)
//   display_select  0: seg carries digit 0, 1: seg carries digit 1
//   digit_0/1[3:0]  last accepted value per digit
//   sum[4:0]        digit_0 + digit_1, registered
//   valid           pulse: legal accept that leaves both digits held
//   full            level: both digits held
//   err             pulse: stable non-blank illegal pattern rejected
module seg_display_decoder #(
  parameter int STABLE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg,
  input  logic       display_select,
  output logic [3:0] digit_0,
  output logic [3:0] digit_1,
  output logic [4:0] sum,
  output logic       valid,
  output logic       full,
  output logic       err
);

  // The state encoding is the have[1:0] vector itself: bit0 = digit 0 held.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HAVE0 = 2'b01,
    HAVE1 = 2'b10,
    FULL  = 2'b11
  } state_t;

  localparam logic [3:0] STABLE = 4'(STABLE_CNT);
  localparam logic [6:0] BLANK  = 7'b1111111;

  state_t     state;
  logic [6:0] seg_q, seg_p;   // current and previous registered sample
  logic       sel_q, sel_p;
  logic [3:0] run_cnt, cnt_nxt;
  logic       accept, blank, dec_ok, ok_acc, bad_acc;
  logic [3:0] dec_val, d0_nxt, d1_nxt;
  logic [1:0] have_nxt;

  // Run length of the registered sample stream. A select toggle with the
  // same segments is a different sample, so it restarts the run.
  always_comb begin
    if ({seg_q, sel_q} == {seg_p, sel_p})
      cnt_nxt = (run_cnt == STABLE) ? run_cnt : run_cnt + 4'd1;
    else
      cnt_nxt = 4'd1;
  end

  // Fires only on the edge the counter first reaches STABLE. Saturation
  // keeps the rest of the run from firing again.
  assign accept = (cnt_nxt == STABLE) && (run_cnt != STABLE);
  assign blank  = (seg_q == BLANK);

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'h0;
    case (seg_q)
      7'b1000000: dec_val = 4'h0;
      7'b1111001: dec_val = 4'h1;
      7'b0100100: dec_val = 4'h2;
      7'b0110000: dec_val = 4'h3;
      7'b0011001: dec_val = 4'h4;
      7'b0010010: dec_val = 4'h5;
      7'b0000010: dec_val = 4'h6;
      7'b1111000: dec_val = 4'h7;
      7'b0000000: dec_val = 4'h8;
      7'b0010000: dec_val = 4'h9;
      7'b0001000: dec_val = 4'hA;
      7'b0000011: dec_val = 4'hB;
      7'b1000110: dec_val = 4'hC;
      7'b0100001: dec_val = 4'hD;
      7'b0000110: dec_val = 4'hE;
      7'b0001110: dec_val = 4'hF;
      default:    dec_ok  = 1'b0;
    endcase
  end

  // The blank pattern is dropped silently. Any other unknown pattern
  // releases the selected digit and keeps its stale value.
  always_comb begin
    ok_acc   = accept && !blank && dec_ok;
    bad_acc  = accept && !blank && !dec_ok;
    have_nxt = state;
    d0_nxt   = digit_0;
    d1_nxt   = digit_1;
    if (ok_acc) begin
      have_nxt[sel_q] = 1'b1;
      if (sel_q) d1_nxt = dec_val;
      else       d0_nxt = dec_val;
    end else if (bad_acc) begin
      have_nxt[sel_q] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_q   <= BLANK;
      sel_q   <= 1'b0;
      seg_p   <= BLANK;
      sel_p   <= 1'b0;
      run_cnt <= 4'd0;
      state   <= EMPTY;
      digit_0 <= 4'h0;
      digit_1 <= 4'h0;
      sum     <= 5'd0;
      valid   <= 1'b0;
      full    <= 1'b0;
      err     <= 1'b0;
    end else begin
      seg_q   <= seg;
      sel_q   <= display_select;
      seg_p   <= seg_q;
      sel_p   <= sel_q;
      run_cnt <= cnt_nxt;
      state   <= state_t'(have_nxt);
      digit_0 <= d0_nxt;
      digit_1 <= d1_nxt;
      sum     <= {1'b0, d0_nxt} + {1'b0, d1_nxt};
      full    <= (have_nxt == 2'b11);
      valid   <= ok_acc && (have_nxt == 2'b11);
      err     <= bad_acc;
    end
  end

endmodule

// File: tb/tb_seg_display_decoder.sv
// Testbench for seg_display_decoder (STABLE_CNT = 4).
// Each valid/err pulse is checked against a queue of hand-computed events
// {err, valid, digit_0, digit_1, sum, full}. A pulse with no queued event
// is reported as unexpected. Outputs are also checked directly at quiet points.
module tb_seg_display_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] seg;
  logic       display_select;
  logic [3:0] digit_0, digit_1;
  logic [4:0] sum;
  logic       valid, full, err;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  localparam logic [6:0] S0 = 7'b1000000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S7 = 7'b1111000, S8 = 7'b0000000, S9 = 7'b0010000,
                         SB = 7'b0000011, SBLK = 7'b1111111, SBAD = 7'b1111110;

  seg_display_decoder #(.STABLE_CNT(4)) dut (
    .clk(clk), .reset(reset), .seg(seg), .display_select(display_select),
    .digit_0(digit_0), .digit_1(digit_1), .sum(sum),
    .valid(valid), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  // Monitor: every pulse must match the oldest queued event.
  always @(negedge clk) begin
    if (valid || err) begin
      logic [15:0] act, exp_v;
      act = {err, valid, digit_0, digit_1, sum, full};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL event unexpected: got %h (err=%0d valid=%0d d0=%h d1=%h sum=%0d full=%0d)",
                 act, err, valid, digit_0, digit_1, sum, full);
      end else begin
        exp_v = exp_q.pop_front();
        if (act !== exp_v) begin
          bad++;
          $display("FAIL event: got %h want %h (err,valid,d0,d1,sum,full)", act, exp_v);
        end
      end
    end
  end

  task automatic expect_ev(input logic e, input logic v, input logic [3:0] d0,
                           input logic [3:0] d1, input logic f);
    logic [4:0] s;
    s = {1'b0, d0} + {1'b0, d1};
    exp_q.push_back({e, v, d0, d1, s, f});
  endtask

  // Drive inputs at a negedge and keep them for n rising edges.
  task automatic hold(input logic sl, input logic [6:0] sg, input int n);
    display_select = sl;
    seg            = sg;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp_v);
    end
  endtask

  initial begin
    reset = 1'b0;
    display_select = 1'b0;
    seg = S8;
    repeat (3) @(negedge clk);
    chk("reset outputs", {digit_0, digit_1, sum, valid, full, err}, 16'h0);

    // A digit-0 zero brings the block to HAVE0 only.
    reset = 1'b1;
    hold(1'b0, S0, 8);
    chk("have0 d0", {12'h0, digit_0}, 16'h0);
    chk("have0 full", {15'h0, full}, 16'h0);

    expect_ev(1'b0, 1'b1, 4'h0, 4'hB, 1'b1);
    hold(1'b1, SB, 8);
    expect_ev(1'b0, 1'b1, 4'h5, 4'hB, 1'b1);
    hold(1'b0, S5, 8);
    // Re-accepting unchanged values still pulses valid.
    expect_ev(1'b0, 1'b1, 4'h5, 4'hB, 1'b1);
    hold(1'b1, SB, 8);
    expect_ev(1'b0, 1'b1, 4'h5, 4'hB, 1'b1);
    hold(1'b0, S5, 8);
    chk("sum 5+B", {11'h0, sum}, 16'd16);
    chk("full after 5,B", {15'h0, full}, 16'h1);

    // A run that is too short must not be accepted. A blank run is ignored.
    hold(1'b0, S4, 3);
    hold(1'b0, SBLK, 10);
    chk("short run d0", {12'h0, digit_0}, 16'h5);
    // A long run is accepted exactly once.
    expect_ev(1'b0, 1'b1, 4'h4, 4'hB, 1'b1);
    hold(1'b0, S4, 20);
    hold(1'b1, SBLK, 10);
    chk("blank d1", {12'h0, digit_1}, 16'hB);

    // Toggling select with the same segments keeps restarting the run.
    for (int i = 0; i < 8; i++) hold(i[0], S8, 2);
    chk("toggle no accept", {digit_0, digit_1, 3'b0, full, err, valid, 2'b0},
        {4'h4, 4'hB, 3'b0, 1'b1, 1'b0, 1'b0, 2'b0});

    // An illegal pattern drops digit 1. The next legal digit restores FULL.
    expect_ev(1'b1, 1'b0, 4'h4, 4'hB, 1'b0);
    hold(1'b1, SBAD, 4);
    expect_ev(1'b0, 1'b1, 4'h4, 4'h8, 1'b1);
    hold(1'b1, S8, 8);

    expect_ev(1'b0, 1'b1, 4'h7, 4'h8, 1'b1);
    hold(1'b0, S7, 8);
    expect_ev(1'b0, 1'b1, 4'h7, 4'h9, 1'b1);
    hold(1'b1, S9, 8);
    chk("7+9 sum", {11'h0, sum}, 16'd16);

    // A one-edge reset while FULL clears everything, and both digits must be re-acquired.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("mid reset outputs", {digit_0, digit_1, sum, valid, full, err}, 16'h0);
    hold(1'b1, S9, 8);
    chk("reacq d1 only", {digit_0, digit_1, 7'h0, full}, {4'h0, 4'h9, 7'h0, 1'b0});
    expect_ev(1'b0, 1'b1, 4'h7, 4'h9, 1'b1);
    hold(1'b0, S7, 8);
    chk("reacq full", {15'h0, full}, 16'h1);

    repeat (3) @(negedge clk);
    chk("events drained", 16'(exp_q.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
